fft_bank_sequencer: RTL and testbench
=====================================

Name: fft_bank_sequencer

Overview:
- Memory-side responder for the FFT address generation unit. Each cycle it accepts one butterfly address pair plus a bank select and a twiddle address.
- Issues the dual-port read on the source ping-pong bank and tracks the pair through the memory and butterfly pipeline. Writes the results back to the opposite bank at the same addresses.
- Counts pairs and stages, flags read-after-write hazards and bank-sequence errors, and signals completion of the full in-place transform.

Parameters:
ADDR_W, 10, bank address width; each stage has 2^(ADDR_W-1) butterflies.
N_STAGES, 10, stages per transform; must be at least 1.
MEM_LAT, 1, bank read latency in cycles (1..4).
BFLY_LAT, 4, butterfly datapath latency from read data to result (1..8).

Ports:
clk  in  1  clock
rst_n  in  1  reset: synchronous, active-low
start_i  in  1  start one transform; honoured only in IDLE
addr_valid_i  in  1  address pair, memsel and twiddle inputs valid this cycle
addr_a_i  in  ADDR_W  butterfly upper operand address
addr_b_i  in  ADDR_W  butterfly lower operand address
memsel_i  in  1  source bank for this pair
twiddle_addr_i  in  ADDR_W-1  twiddle ROM address
rd_en_o  out  1  bank read strobe
rd_bank_o  out  1  bank being read
rd_addr_a_o  out  ADDR_W  read port A address
rd_addr_b_o  out  ADDR_W  read port B address
tw_addr_o  out  ADDR_W-1  twiddle ROM address, aligned with rd_en_o
bfly_valid_o  out  1  read data valid at butterfly input
wr_en_o  out  1  result write strobe
wr_bank_o  out  1  bank being written (= NOT source bank)
wr_addr_a_o  out  ADDR_W  write port A address
wr_addr_b_o  out  ADDR_W  write port B address
stage_o  out  4  current read stage index
busy_o  out  1  high in RUN or DRAIN
done_o  out  1  one-cycle completion pulse
hazard_o  out  1  sticky: read hit an in-flight write
seq_err_o  out  1  sticky: memsel_i != stage_o[0]

Behaviour:
- Reset: every output 0. FSM goes to IDLE. Pair counter, stage counter and delay line are cleared; all in-flight entries are discarded with no write issued. Reset mid-operation is identical.
- FSM states are IDLE, RUN, DRAIN.
- IDLE:
  - start_i=1 clears the counters, hazard_o and seq_err_o, then goes to RUN.
  - addr_valid_i is ignored in IDLE.
- RUN:
  - Each cycle with addr_valid_i=1, rd_en_o, rd_bank_o(=memsel_i), rd_addr_a_o, rd_addr_b_o and tw_addr_o are registered on the next cycle (1-cycle latency).
  - With addr_valid_i=0, rd_en_o=0 next cycle, the address outputs hold, and the counters hold.
  - The pair counter (ADDR_W-1 bits) increments per accepted pair. On wrap from 2^(ADDR_W-1)-1 to 0, stage_o increments.
  - Accepting the last pair of stage N_STAGES-1 moves to DRAIN. stage_o holds N_STAGES-1.
- Delay line:
  - Depth D = MEM_LAT+BFLY_LAT, shifting every cycle. Each entry holds {valid, bank, addr_a, addr_b}.
  - bfly_valid_o is asserted exactly MEM_LAT cycles after rd_en_o.
  - wr_en_o, wr_bank_o=~rd_bank and the addresses are asserted exactly D cycles after the matching rd_en_o.
  - Bubbles propagate as invalid entries.
  - Write addresses hold their last value when wr_en_o=0.
- DRAIN:
  - Accepts no new pairs; addr_valid_i is ignored.
  - When the last valid entry is written (wr_en_o high that cycle), done_o=1 on the following cycle and the FSM returns to IDLE.
- busy_o = 1 in RUN and DRAIN; 0 in IDLE, including the done_o cycle.
- Hazard check: on an accepted pair, compare addr_a_i and addr_b_i against both addresses of every valid delay-line entry whose write bank equals memsel_i. Any match sets hazard_o the next cycle. The read still issues; there is no stall.
- Sequence check: an accepted pair with memsel_i != stage_o[0] sets seq_err_o the next cycle.
- start_i while busy is ignored.
- start_i in the done_o cycle is accepted, since the FSM is already in IDLE.
- No arithmetic beyond counters; all counters wrap modulo their width.

Test Plan:
- ADDR_W=4, N_STAGES=4, MEM_LAT=1, BFLY_LAT=4; drive 32 contiguous valid pairs with correct memsel -> 32 rd_en_o pulses and 32 wr_en_o pulses, each 5 cycles after its read, wr_bank=~rd_bank. done_o pulses once, the cycle after the last write. No flags.
- Same config, pair {a=3,b=11} in stage 0 -> rd_addr 3/11 on bank 0 at T+1, bfly_valid at T+2, wr 3/11 on bank 1 at T+6. stage_o=1 after the 8th pair.
- Insert a 3-cycle addr_valid_i gap mid-stage -> 3-cycle gaps in both the rd_en_o and wr_en_o streams. Counters hold; total writes remain 32.
- First pair of stage 1 reads addr 7 on bank 1 while the stage-0 write of 7 to bank 1 is in flight -> hazard_o=1 next cycle and stays high until the next start_i.
- Pair in stage 2 with memsel_i=1 -> seq_err_o=1. Assert rst_n=0 during DRAIN with 3 entries in flight -> no further wr_en_o or done_o, all outputs 0.
- start_i pulsed during RUN -> no effect. start_i in the done_o cycle -> new run begins, stage_o=0, flags cleared.

Source files
------------

// File: rtl/fft_bank_sequencer.sv
// Memory-side sequencer for the in-place FFT: issues ping-pong bank reads, tracks
// each butterfly pair through memory and datapath latency, and writes results to the other bank.
module fft_bank_sequencer #(
    parameter int ADDR_W   = 10,
    parameter int N_STAGES = 10,
    parameter int MEM_LAT  = 1,
    parameter int BFLY_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              addr_valid_i,
    input  logic [ADDR_W-1:0] addr_a_i,
    input  logic [ADDR_W-1:0] addr_b_i,
    input  logic              memsel_i,
    input  logic [ADDR_W-2:0] twiddle_addr_i,
    output logic              rd_en_o,
    output logic              rd_bank_o,
    output logic [ADDR_W-1:0] rd_addr_a_o,
    output logic [ADDR_W-1:0] rd_addr_b_o,
    output logic [ADDR_W-2:0] tw_addr_o,
    output logic              bfly_valid_o,
    output logic              wr_en_o,
    output logic              wr_bank_o,
    output logic [ADDR_W-1:0] wr_addr_a_o,
    output logic [ADDR_W-1:0] wr_addr_b_o,
    output logic [3:0]        stage_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              hazard_o,
    output logic              seq_err_o
);

    localparam int D  = MEM_LAT + BFLY_LAT;
    localparam int PW = ADDR_W - 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic              valid;
        logic              bank;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;
    } entry_t;

    state_t        state, state_nxt;
    logic [PW-1:0] pair_cnt;
    entry_t        pipe [D-1];
    entry_t        cur  [D];
    logic          accept, last_pair, any_valid, hit, drain_done;

    // cur[0] is the read being issued now; cur[i] is that read i cycles later.
    always_comb begin
        cur[0] = '{valid: rd_en_o, bank: rd_bank_o, a: rd_addr_a_o, b: rd_addr_b_o};
        for (int i = 1; i < D; i++) cur[i] = pipe[i-1];
    end

    // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        any_valid = 1'b0;
        hit       = 1'b0;
        for (int i = 0; i < D; i++) begin
            if (cur[i].valid) begin
                any_valid = 1'b1;
                if ((cur[i].bank != memsel_i) &&
                    (addr_a_i == cur[i].a || addr_a_i == cur[i].b ||
                     addr_b_i == cur[i].a || addr_b_i == cur[i].b))
                    hit = 1'b1;
            end
        end
    end

    assign accept     = (state == RUN) && addr_valid_i;
    assign last_pair  = (&pair_cnt) && (stage_o == 4'(N_STAGES - 1));
    assign drain_done = (state == DRAIN) && wr_en_o && !any_valid;
    assign busy_o     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = RUN;
            RUN:     if (accept && last_pair) state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_en_o      <= 1'b0;
            rd_bank_o    <= 1'b0;
            rd_addr_a_o  <= '0;
            rd_addr_b_o  <= '0;
            tw_addr_o    <= '0;
            bfly_valid_o <= 1'b0;
            wr_en_o      <= 1'b0;
            wr_bank_o    <= 1'b0;
            wr_addr_a_o  <= '0;
            wr_addr_b_o  <= '0;
            done_o       <= 1'b0;
            pair_cnt     <= '0;
            stage_o      <= '0;
            hazard_o     <= 1'b0;
            seq_err_o    <= 1'b0;
            // NOTE: the delay line is cleared on reset so in-flight pairs never produce a write afterwards.
            for (int i = 0; i < D-1; i++) pipe[i] <= '0;
        end else begin
            rd_en_o <= accept;
            if (accept) begin
                rd_bank_o   <= memsel_i;
                rd_addr_a_o <= addr_a_i;
                rd_addr_b_o <= addr_b_i;
                tw_addr_o   <= twiddle_addr_i;
            end

            bfly_valid_o <= cur[MEM_LAT-1].valid;
            pipe[0]      <= cur[0];
            for (int i = 1; i < D-1; i++) pipe[i] <= pipe[i-1];

            // Results land in the opposite bank; addresses hold between writes.
            wr_en_o <= cur[D-1].valid;
            if (cur[D-1].valid) begin
                wr_bank_o   <= ~cur[D-1].bank;
                wr_addr_a_o <= cur[D-1].a;
                wr_addr_b_o <= cur[D-1].b;
            end

            done_o <= drain_done;

            if (state == IDLE && start_i) begin
                pair_cnt  <= '0;
                stage_o   <= '0;
                hazard_o  <= 1'b0;
                seq_err_o <= 1'b0;
            end else if (accept) begin
                pair_cnt <= pair_cnt + PW'(1);
                if ((&pair_cnt) && !last_pair) stage_o <= stage_o + 4'd1;
                if (hit) hazard_o <= 1'b1;
                if (memsel_i != stage_o[0]) seq_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_bank_sequencer.sv
// Directed bench for fft_bank_sequencer (ADDR_W=4, N_STAGES=4): a scoreboard holds the
// expected read, butterfly-valid and write events with the cycle each must appear in.
module tb_fft_bank_sequencer;

    localparam int ML = 1;
    localparam int D  = 5;

    logic       clk = 1'b0;
    logic       rst_n, start_i, addr_valid_i, memsel_i;
    logic [3:0] addr_a_i, addr_b_i;
    logic [2:0] twiddle_addr_i;
    logic       rd_en_o, rd_bank_o, bfly_valid_o, wr_en_o, wr_bank_o;
    logic [3:0] rd_addr_a_o, rd_addr_b_o, wr_addr_a_o, wr_addr_b_o, stage_o;
    logic [2:0] tw_addr_o;
    logic       busy_o, done_o, hazard_o, seq_err_o;
    logic [31:0] all_outs;

    fft_bank_sequencer #(.ADDR_W(4), .N_STAGES(4), .MEM_LAT(ML), .BFLY_LAT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .addr_valid_i(addr_valid_i),
        .addr_a_i(addr_a_i), .addr_b_i(addr_b_i), .memsel_i(memsel_i),
        .twiddle_addr_i(twiddle_addr_i), .rd_en_o(rd_en_o), .rd_bank_o(rd_bank_o),
        .rd_addr_a_o(rd_addr_a_o), .rd_addr_b_o(rd_addr_b_o), .tw_addr_o(tw_addr_o),
        .bfly_valid_o(bfly_valid_o), .wr_en_o(wr_en_o), .wr_bank_o(wr_bank_o),
        .wr_addr_a_o(wr_addr_a_o), .wr_addr_b_o(wr_addr_b_o), .stage_o(stage_o),
        .busy_o(busy_o), .done_o(done_o), .hazard_o(hazard_o), .seq_err_o(seq_err_o)
    );

    assign all_outs = {rd_en_o, rd_bank_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o, bfly_valid_o,
                       wr_en_o, wr_bank_o, wr_addr_a_o, wr_addr_b_o, stage_o, busy_o, done_o,
                       hazard_o, seq_err_o};

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       bank;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] tw;
    } exp_t;

    exp_t rd_q[$];
    exp_t wr_q[$];
    int   bf_q[$];
    exp_t e_rd, e_wr;
    int   cyc = 0;
    int   checks = 0, failures = 0;
    int   wr_cnt = 0, done_cnt = 0, last_wr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Monitor: every strobe must match the head of its queue in both cycle and content.
    always @(negedge clk) begin
        while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
            check("rd_due", cyc, rd_q[0].cyc);
            void'(rd_q.pop_front());
        end
        while (bf_q.size() > 0 && bf_q[0] < cyc) begin
            check("bfly_due", cyc, bf_q[0]);
            void'(bf_q.pop_front());
        end
        while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
            check("wr_due", cyc, wr_q[0].cyc);
            void'(wr_q.pop_front());
        end
        if (rd_en_o === 1'b1) begin
            if (rd_q.size() == 0) check("rd_spurious", 32'(rd_en_o), 32'd0);
            else begin
                e_rd = rd_q.pop_front();
                check("rd_cyc", cyc, e_rd.cyc);
                check("rd_bank", 32'(rd_bank_o), 32'(e_rd.bank));
                check("rd_addr_a", 32'(rd_addr_a_o), 32'(e_rd.a));
                check("rd_addr_b", 32'(rd_addr_b_o), 32'(e_rd.b));
                check("tw_addr", 32'(tw_addr_o), 32'(e_rd.tw));
            end
        end
        if (bfly_valid_o === 1'b1) begin
            if (bf_q.size() == 0) check("bfly_spurious", 32'(bfly_valid_o), 32'd0);
            else check("bfly_cyc", cyc, bf_q.pop_front());
        end
        if (wr_en_o === 1'b1) begin
            wr_cnt++;
            if (wr_q.size() == 0) check("wr_spurious", 32'(wr_en_o), 32'd0);
            else begin
                e_wr = wr_q.pop_front();
                check("wr_cyc", cyc, e_wr.cyc);
                check("wr_bank", 32'(wr_bank_o), 32'(e_wr.bank));
                check("wr_addr_a", 32'(wr_addr_a_o), 32'(e_wr.a));
                check("wr_addr_b", 32'(wr_addr_b_o), 32'(e_wr.b));
            end
        end
        if (done_o === 1'b1) done_cnt++;
    end

    // Drive one cycle of address input; when acc is set the pair is expected to be accepted.
    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic ms, input logic [2:0] tw, input bit acc);
        addr_valid_i   = v;
        addr_a_i       = a;
        addr_b_i       = b;
        memsel_i       = ms;
        twiddle_addr_i = tw;
        if (acc && v) begin
            rd_q.push_back('{cyc + 1, ms, a, b, tw});
            bf_q.push_back(cyc + 1 + ML);
            wr_q.push_back('{cyc + 1 + D, ~ms, a, b, tw});
            last_wr = cyc + 1 + D;
        end
        @(posedge clk); #1;
        addr_valid_i = 1'b0;
    endtask

    task automatic pair(input int k, input int ms);
        drive(1'b1, 4'(k), 4'(k + 8), 1'(ms), 3'(k), 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 4'd0, 4'd0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_o !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done_o), 32'd1);
        check("done_cyc", cyc, last_wr + 1);
        check("done_busy", 32'(busy_o), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; addr_valid_i = 1'b0; memsel_i = 1'b0;
        addr_a_i = '0; addr_b_i = '0; twiddle_addr_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", all_outs, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Run 1: gap, hazard, start-while-busy, sequence error, then restart in the done cycle.
        drive(1'b1, 4'd5, 4'd13, 1'b0, 3'd5, 1'b0);
        check("idle_ignores_valid", 32'(rd_en_o), 32'd0);
        check("idle_busy", 32'(busy_o), 32'd0);
        pulse_start();
        check("start_busy", 32'(busy_o), 32'd1);
        check("start_stage", 32'(stage_o), 32'd0);
        for (int k = 0; k < 4; k++) pair(k, 0);
        idle(3);
        check("gap_rd_hold", 32'(rd_addr_a_o), 32'd3);
        check("gap_stage_hold", 32'(stage_o), 32'd0);
        for (int k = 4; k < 8; k++) pair(k, 0);
        check("stage1_reached", 32'(stage_o), 32'd1);
        check("pre_hazard", 32'(hazard_o), 32'd0);
        pair(7, 1);
        check("hazard_set", 32'(hazard_o), 32'd1);
        pair(1, 1);
        pair(2, 1);
        start_i = 1'b1;
        pair(3, 1);
        start_i = 1'b0;
        check("busy_start_stage", 32'(stage_o), 32'd1);
        check("busy_start_hazard", 32'(hazard_o), 32'd1);
        check("pre_seq_err", 32'(seq_err_o), 32'd0);
        pair(4, 1); pair(5, 1); pair(6, 1); pair(0, 1);
        check("stage2_reached", 32'(stage_o), 32'd2);
        pair(0, 1);
        check("seq_err_set", 32'(seq_err_o), 32'd1);
        for (int k = 1; k < 8; k++) pair(k, 0);
        for (int k = 0; k < 8; k++) pair(k, 1);
        check("drain_busy", 32'(busy_o), 32'd1);
        check("drain_stage", 32'(stage_o), 32'd3);
        wait_done();
        check("run1_writes", wr_cnt, 32'd32);
        check("run1_flags", {30'd0, hazard_o, seq_err_o}, 32'd3);
        pulse_start();
        check("restart_busy", 32'(busy_o), 32'd1);
        check("restart_stage", 32'(stage_o), 32'd0);
        check("restart_flags", {30'd0, hazard_o, seq_err_o}, 32'd0);
        wr_cnt   = 0;
        done_cnt = 0;

        // Run 2: 32 contiguous pairs with correct bank sequencing.
        for (int i = 0; i < 32; i++) begin
            pair(i % 8, (i / 8) % 2);
            if (i == 7) check("stage_after_8", 32'(stage_o), 32'd1);
        end
        wait_done();
        idle(5);
        check("run2_done_once", done_cnt, 32'd1);
        check("run2_writes", wr_cnt, 32'd32);
        check("run2_flags", {30'd0, hazard_o, seq_err_o}, 32'd0);

        // Run 3: reset during DRAIN with three pairs still in flight.
        pulse_start();
        for (int i = 0; i < 32; i++) pair(i % 8, (i / 8) % 2);
        idle(2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rd_q.delete();
        bf_q.delete();
        wr_q.delete();
        check("drain_reset_outs", all_outs, 32'd0);
        repeat (8) begin
            @(negedge clk);
            check("reset_no_wr", 32'(wr_en_o), 32'd0);
            check("reset_no_done", 32'(done_o), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_outs", all_outs, 32'd0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
